// File: rtl/l2_plru_lock_if.sv
// l2_plru_lock_if
//   Request/response bundle between the L2 tag pipeline and the PLRU/lock
//   tracker.
//   master (tag pipeline): drives fill/access requests, lock controls and
//                          the stage-2 hit update; receives fill_way.
//   slave  (tracker):      the reverse.
//   Signals:
//     fill_en, fill_set          fill request and its set
//     fill_way                   victim way, valid the cycle after fill_en
//     lock_en, lock_value        lock-bit update (1 = lock, 0 = unlock)
//     access_en, access_set      lookup request and its set
//     access_update_en/_way      hit, one cycle after access_en
interface l2_plru_lock_if #(
   parameter int NUM_SETS = 1,
   parameter int NUM_WAYS = 4
);
   localparam int SET_INDEX_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
   localparam int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

   logic                       fill_en;
   logic [SET_INDEX_WIDTH-1:0] fill_set;
   logic [WAY_INDEX_WIDTH-1:0] fill_way;
   logic                       lock_en;
   logic                       lock_value;
   logic                       access_en;
   logic [SET_INDEX_WIDTH-1:0] access_set;
   logic                       access_update_en;
   logic [WAY_INDEX_WIDTH-1:0] access_update_way;

   modport master (
      output fill_en, fill_set, lock_en, lock_value,
      output access_en, access_set, access_update_en, access_update_way,
      input  fill_way
   );

   modport slave (
      input  fill_en, fill_set, lock_en, lock_value,
      input  access_en, access_set, access_update_en, access_update_way,
      output fill_way
   );
endinterface

// File: rtl/l2_plru_lock.sv
// l2_plru_lock
//   Per-set pseudo-LRU (PLRUm) victim selection with per-way lock bits.
//   Stage 1 registers the MRU and lock rows of the requested set; stage 2
//   picks the victim (lowest way neither MRU nor locked) and writes the
//   updated MRU/lock rows back.  Same-set reads during a write see the new
//   data, so back-to-back requests on one set observe each other.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset; clears arrays and pipeline
//     bus    l2_plru_lock_if.slave request/response bundle
module l2_plru_lock #(
   parameter int NUM_SETS = 1,
   parameter int NUM_WAYS = 4
) (
   input  logic           clk,
   input  logic           reset,
   l2_plru_lock_if.slave  bus
);
   localparam int SET_INDEX_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
   localparam int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   // Rows are rounded up to the full index range so every index value
   // addresses a real row.
   localparam int DEPTH = 2 ** SET_INDEX_WIDTH;

   generate
      if (!(NUM_WAYS == 1 || NUM_WAYS == 2 || NUM_WAYS == 4 || NUM_WAYS == 8)) begin : g_bad_ways
         $error("l2_plru_lock: NUM_WAYS must be 1, 2, 4 or 8");
      end
   endgenerate

   logic [NUM_WAYS-1:0]        mru_mem  [DEPTH];
   logic [NUM_WAYS-1:0]        lock_mem [DEPTH];

   logic [NUM_WAYS-1:0]        mru_rd_reg, mru_rd_next;
   logic [NUM_WAYS-1:0]        lock_rd_reg, lock_rd_next;
   logic [SET_INDEX_WIDTH-1:0] update_set_reg;
   logic                       was_fill_reg;
   logic                       was_lock_reg;
   logic                       lock_value_q_reg;
   logic                       was_access_reg;

   logic [SET_INDEX_WIDTH-1:0] read_set;
   logic                       mru_rd_en, lock_rd_en;
   logic [NUM_WAYS-1:0]        used;
   logic [WAY_INDEX_WIDTH-1:0] victim_way;
   logic [WAY_INDEX_WIDTH-1:0] upd_way;
   logic [NUM_WAYS-1:0]        upd_oh;
   logic [NUM_WAYS-1:0]        mru_calc;
   logic [NUM_WAYS-1:0]        mru_wr_data, lock_wr_data;
   logic                       mru_wr_en, lock_wr_en;

   // Fill has priority over access for the shared read port.
   assign read_set   = bus.fill_en ? bus.fill_set : bus.access_set;
   assign mru_rd_en  = bus.fill_en | bus.access_en;
   assign lock_rd_en = bus.fill_en | bus.access_en | bus.lock_en;

   // Victim: lowest way that is neither MRU nor locked; way 0 if none.
   assign used = mru_rd_reg | lock_rd_reg;

   always_comb begin
      victim_way = '0;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (!used[i]) victim_way = WAY_INDEX_WIDTH'(i);
      end
   end

   assign bus.fill_way = victim_way;

   // A fill always updates its own victim, so a stale hit update in the
   // same stage cannot steer the way choice.
   assign upd_way = was_fill_reg ? victim_way : bus.access_update_way;

   generate
      for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_upd_oh
         assign upd_oh[gi] = (upd_way == WAY_INDEX_WIDTH'(gi));
      end
   endgenerate

   // When marking this way would leave no candidate, restart the MRU row
   // from just this way; if even that leaves nothing free (all other ways
   // locked), clear the row entirely.
   always_comb begin
      if (&(mru_rd_reg | upd_oh | lock_rd_reg))
         mru_calc = (&(upd_oh | lock_rd_reg)) ? '0 : upd_oh;
      else
         mru_calc = mru_rd_reg | upd_oh;
   end

   assign mru_wr_en    = was_fill_reg | bus.access_update_en;
   assign mru_wr_data  = (NUM_WAYS == 1) ? '0 : mru_calc;
   assign lock_wr_en   = was_lock_reg;
   assign lock_wr_data = lock_value_q_reg ? (lock_rd_reg | upd_oh)
                                          : (lock_rd_reg & ~upd_oh);

   // Read with write-forwarding for a same-set write this cycle.
   assign mru_rd_next  = (mru_wr_en && update_set_reg == read_set)
                         ? mru_wr_data : mru_mem[read_set];
   assign lock_rd_next = (lock_wr_en && update_set_reg == read_set)
                         ? lock_wr_data : lock_mem[read_set];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mru_mem[i]  <= '0;
            lock_mem[i] <= '0;
         end
         mru_rd_reg       <= '0;
         lock_rd_reg      <= '0;
         update_set_reg   <= '0;
         was_fill_reg     <= 1'b0;
         was_lock_reg     <= 1'b0;
         lock_value_q_reg <= 1'b0;
         was_access_reg   <= 1'b0;
      end else begin
         if (mru_wr_en)  mru_mem[update_set_reg]  <= mru_wr_data;
         if (lock_wr_en) lock_mem[update_set_reg] <= lock_wr_data;
         if (mru_rd_en)  mru_rd_reg  <= mru_rd_next;
         if (lock_rd_en) lock_rd_reg <= lock_rd_next;
         update_set_reg   <= read_set;
         was_fill_reg     <= bus.fill_en;
         was_lock_reg     <= bus.lock_en;
         lock_value_q_reg <= bus.lock_value;
         was_access_reg   <= bus.access_en;
      end
   end

   // A hit update must follow an access lookup by exactly one cycle.
   a_update_after_access: assert property (
      @(posedge clk) disable iff (!reset) bus.access_update_en |-> was_access_reg
   );

endmodule

// File: tb/tb_l2_plru_lock.sv
// tb_l2_plru_lock
//   Directed bench for l2_plru_lock with 4 sets x 4 ways.  Expected victim
//   ways are queued when a fill is driven and popped when fill_way is
//   sampled; array contents are checked against hand-derived constants.
module tb_l2_plru_lock;
   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   exp_q[$];

   l2_plru_lock_if #(.NUM_SETS(4), .NUM_WAYS(4)) bus ();

   l2_plru_lock #(.NUM_SETS(4), .NUM_WAYS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive request + stage-2 update, clock, then compare the
   // victim way against the queued expectation (exp < 0: no fill check).
   task automatic step(input bit f, input bit [1:0] fs, input bit a, input bit [1:0] as_,
                       input bit le, input bit lv, input bit ue, input bit [1:0] uw,
                       input int exp);
      int e;
      bus.fill_en           = f;
      bus.fill_set          = fs;
      bus.access_en         = a;
      bus.access_set        = as_;
      bus.lock_en           = le;
      bus.lock_value        = lv;
      bus.access_update_en  = ue;
      bus.access_update_way = uw;
      if (exp >= 0) exp_q.push_back(exp);
      @(posedge clk);
      #1;
      if (exp >= 0) begin
         e = exp_q.pop_front();
         $display("TXN fill set=%0d lock_en=%0b fill_way=%0d expected=%0d",
                  fs, le, bus.fill_way, e);
         check("fill_way", 32'(bus.fill_way), 32'(e));
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, -1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      bus.fill_en = 0; bus.fill_set = 0; bus.access_en = 0; bus.access_set = 0;
      bus.lock_en = 0; bus.lock_value = 0; bus.access_update_en = 0; bus.access_update_way = 0;
      #3;
      check("reset_fill_way", 32'(bus.fill_way), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      check("reset_mru0", 32'(dut.mru_mem[0]), 0);
      check("reset_lock0", 32'(dut.lock_mem[0]), 0);

      // Four back-to-back fills to set 0, then a fifth.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 3);
      idle();
      check("mru0_after4", 32'(dut.mru_mem[0]), 32'b1000);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      check("mru0_after5", 32'(dut.mru_mem[0]), 32'b1001);

      // Hit update on set 1.
      step(0, 0, 1, 1, 0, 0, 0, 0, -1);
      step(0, 0, 0, 0, 0, 0, 1, 2, -1);
      check("mru1_hit", 32'(dut.mru_mem[1]), 32'b0100);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      idle();
      check("mru1_fill", 32'(dut.mru_mem[1]), 32'b0101);
      step(1, 1, 0, 0, 0, 0, 0, 0, 1);
      idle();

      // Lock / unlock on set 2.
      step(1, 2, 0, 0, 1, 1, 0, 0, 0);
      idle();
      check("lock2_set", 32'(dut.lock_mem[2]), 32'b0001);
      step(1, 2, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 1, 2, 1, 0, 0, 0, -1);
      step(0, 0, 0, 0, 0, 0, 1, 0, -1);
      check("lock2_clear", 32'(dut.lock_mem[2]), 32'b0000);
      check("mru2_hit", 32'(dut.mru_mem[2]), 32'b0011);

      // Lock every way of set 2, then fill with everything locked.
      step(1, 2, 0, 0, 1, 1, 0, 0, 2);
      step(1, 2, 0, 0, 1, 1, 0, 0, 3);
      step(1, 2, 0, 0, 1, 1, 0, 0, 0);
      step(1, 2, 0, 0, 1, 1, 0, 0, 1);
      step(1, 2, 0, 0, 0, 0, 0, 0, 0);
      idle();
      check("lock2_all", 32'(dut.lock_mem[2]), 32'b1111);
      check("mru2_all_locked", 32'(dut.mru_mem[2]), 32'b0000);

      // Simultaneous fill (set 3) and access (set 0): fill wins.
      step(1, 3, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 3, -1);
      check("mru3_fill_wins", 32'(dut.mru_mem[3]), 32'b0001);
      check("mru0_untouched", 32'(dut.mru_mem[0]), 32'b1001);

      // Fill in flight, then asynchronous reset mid-cycle.
      step(1, 0, 0, 0, 0, 0, 0, 0, 1);
      bus.fill_en = 0;
      #2 reset = 1'b0;
      #1;
      check("async_reset_fill_way", 32'(bus.fill_way), 0);
      @(posedge clk);
      #1 reset = 1'b1;
      for (int s = 0; s < 4; s++) begin
         check($sformatf("post_reset_mru%0d", s), 32'(dut.mru_mem[s]), 0);
         check($sformatf("post_reset_lock%0d", s), 32'(dut.lock_mem[s]), 0);
      end
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      check("post_reset_mru0_fill", 32'(dut.mru_mem[0]), 32'b0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
